// File: rtl/dot4_seq.sv
// dot4_seq: four-row matrix-vector product y = W*z using one shared
// multiplier over 16 MAC cycles; all four results publish together.
module dot4_seq #(
  parameter int FRAC = 13,
  parameter int W    = 26
) (
  input  logic                clk_dot,
  input  logic                rstn_dot,
  input  logic                en_dot,
  input  logic                start,
  input  logic signed [W-1:0] z1,
  input  logic signed [W-1:0] z2,
  input  logic signed [W-1:0] z3,
  input  logic signed [W-1:0] z4,
  input  logic signed [W-1:0] w11,
  input  logic signed [W-1:0] w12,
  input  logic signed [W-1:0] w13,
  input  logic signed [W-1:0] w14,
  input  logic signed [W-1:0] w21,
  input  logic signed [W-1:0] w22,
  input  logic signed [W-1:0] w23,
  input  logic signed [W-1:0] w24,
  input  logic signed [W-1:0] w31,
  input  logic signed [W-1:0] w32,
  input  logic signed [W-1:0] w33,
  input  logic signed [W-1:0] w34,
  input  logic signed [W-1:0] w41,
  input  logic signed [W-1:0] w42,
  input  logic signed [W-1:0] w43,
  input  logic signed [W-1:0] w44,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic signed [W-1:0] y3,
  output logic signed [W-1:0] y4,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  localparam int AW = 2*W + 2;
  localparam logic signed [AW-1:0] MAXV =
    {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(W+3){1'b1}}, {(W-1){1'b0}}};

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0] z_q [4];
  logic signed [W-1:0] z_d [4];
  logic signed [W-1:0] w_q [16];
  logic signed [W-1:0] w_d [16];
  logic signed [W-1:0] s_q [4];
  logic signed [W-1:0] s_d [4];
  logic signed [W-1:0] y_q [4];
  logic signed [W-1:0] y_d [4];
  logic signed [W-1:0] z_in [4];
  logic signed [W-1:0] w_in [16];

  logic signed [2*W-1:0] wx, zx, prod;
  logic signed [AW-1:0] sum, shr;
  logic signed [W-1:0] r;

  always_comb begin
    z_in = '{z1, z2, z3, z4};
    w_in = '{w11, w12, w13, w14,
             w21, w22, w23, w24,
             w31, w32, w33, w34,
             w41, w42, w43, w44};
  end

  // Datapath: one product per cycle, row result formed from acc+product.
  always_comb begin
    wx   = {{W{w_q[cnt_q][W-1]}}, w_q[cnt_q]};
    zx   = {{W{z_q[cnt_q[1:0]][W-1]}}, z_q[cnt_q[1:0]]};
    prod = wx * zx;
    sum  = acc_q + {{2{prod[2*W-1]}}, prod};
    shr  = sum >>> FRAC;
    if (shr > MAXV)      r = MAXV[W-1:0];
    else if (shr < MINV) r = MINV[W-1:0];
    else                 r = shr[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    z_d     = z_q;
    w_d     = w_q;
    s_d     = s_q;
    y_d     = y_q;
    if (en_dot) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            z_d     = z_in;
            w_d     = w_in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MAC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MAC: begin
          cnt_d = cnt_q + 4'd1;
          acc_d = sum;
          if (cnt_q[1:0] == 2'd3) begin
            acc_d            = '0;
            s_d[cnt_q[3:2]]  = r;
          end
          if (cnt_q == 4'd15) begin
            y_d     = s_d;
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_dot or negedge rstn_dot) begin
    if (!rstn_dot) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        z_q[i] <= '0;
        s_q[i] <= '0;
        y_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      w_q     <= w_d;
      s_q     <= s_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q == S_MAC);
  assign done = (state_q == S_DONE);
  assign y1   = y_q[0];
  assign y2   = y_q[1];
  assign y3   = y_q[2];
  assign y4   = y_q[3];

endmodule
